// File: rtl/fence_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fence_sequencer_if : commit / store-buffer / cache / TLB side of the fence
//                      sequencer, grouped as one bundle.        Rev 1.0
// ---------------------------------------------------------------------------
interface fence_sequencer_if;
  logic fence_i;
  logic fence_i_i;
  logic sfence_vma_i;
  logic fence_t_i;
  logic no_st_pending_i;
  logic dcache_flush_o;
  logic dcache_flush_ack_i;
  logic icache_flush_o;
  logic tlb_flush_o;
  logic flush_pipeline_o;
  logic busy_o;
  logic done_o;

  // master: the surrounding core (commit, store buffer, caches)
  modport master (
    output fence_i, fence_i_i, sfence_vma_i, fence_t_i,
    output no_st_pending_i, dcache_flush_ack_i,
    input  dcache_flush_o, icache_flush_o, tlb_flush_o,
    input  flush_pipeline_o, busy_o, done_o
  );

  modport slave (
    input  fence_i, fence_i_i, sfence_vma_i, fence_t_i,
    input  no_st_pending_i, dcache_flush_ack_i,
    output dcache_flush_o, icache_flush_o, tlb_flush_o,
    output flush_pipeline_o, busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/fence_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fence_sequencer : orders store drain, D$ flush, I$/TLB flush and FENCE.T
//                   padding for one committed fence at a time.  Rev 1.0
// ---------------------------------------------------------------------------
module fence_sequencer #(
  parameter bit          DcacheWriteback = 1'b1,
  parameter int unsigned FenceTPadCycles = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fence_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_DFLUSH = 3'd2,
    S_CFLUSH = 3'd3,
    S_PAD    = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_FENCE   = 2'd0,
    OP_FENCE_I = 2'd1,
    OP_SFENCE  = 2'd2,
    OP_FENCE_T = 2'd3
  } op_e;

  localparam int unsigned CntW = (FenceTPadCycles > 0) ? $clog2(FenceTPadCycles + 1) : 1;
  localparam logic [CntW-1:0] PadLoad =
    (FenceTPadCycles > 0) ? CntW'(FenceTPadCycles - 1) : '0;

  state_e          state_q;
  op_e             op_q;
  logic [CntW-1:0] cnt_q;
  logic            dflush_q;
  logic            icache_q;
  logic            tlb_q;
  logic            done_q;
  logic            busy_q;

  logic req_any;
  op_e  req_op;
  logic need_dflush;
  logic cflush_ic;
  logic cflush_tlb;

  // Fixed priority: FENCE.T > FENCE.I > FENCE > SFENCE.VMA
  always_comb begin
    req_any = bus.fence_t_i | bus.fence_i_i | bus.fence_i | bus.sfence_vma_i;
    req_op  = OP_SFENCE;
    if (bus.fence_t_i)      req_op = OP_FENCE_T;
    else if (bus.fence_i_i) req_op = OP_FENCE_I;
    else if (bus.fence_i)   req_op = OP_FENCE;
  end

  assign need_dflush = (op_q == OP_FENCE_T) || (DcacheWriteback && (op_q != OP_SFENCE));
  assign cflush_ic   = (op_q == OP_FENCE_I) || (op_q == OP_FENCE_T);
  assign cflush_tlb  = (op_q == OP_SFENCE)  || (op_q == OP_FENCE_T);

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= OP_FENCE;
      cnt_q    <= '0;
      dflush_q <= 1'b0;
      icache_q <= 1'b0;
      tlb_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      dflush_q <= 1'b0;
      icache_q <= 1'b0;
      tlb_q    <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            state_q <= S_DRAIN;
            op_q    <= req_op;
            busy_q  <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (bus.no_st_pending_i) begin
            if (need_dflush) begin
              state_q  <= S_DFLUSH;
              dflush_q <= 1'b1;
            end else if (op_q == OP_FENCE) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_CFLUSH;
              icache_q <= cflush_ic;
              tlb_q    <= cflush_tlb;
            end
          end
        end
        S_DFLUSH: begin
          if (!bus.dcache_flush_ack_i) begin
            dflush_q <= 1'b1;
          end else if (op_q == OP_FENCE) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q  <= S_CFLUSH;
            icache_q <= cflush_ic;
            tlb_q    <= cflush_tlb;
          end
        end
        S_CFLUSH: begin
          if ((op_q == OP_FENCE_T) && (FenceTPadCycles > 0)) begin
            state_q <= S_PAD;
            cnt_q   <= PadLoad;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_PAD: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dcache_flush_o   = dflush_q;
  assign bus.icache_flush_o   = icache_q;
  assign bus.tlb_flush_o      = tlb_q;
  assign bus.flush_pipeline_o = done_q;
  assign bus.done_o           = done_q;
  assign bus.busy_o           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fence_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fence_sequencer : two sequencer configurations driven in lockstep and
//                      compared cycle by cycle to a step-list model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_fence_sequencer;

  logic clk;
  logic rst_n;
  logic fn, fii, sv, ft, nsp, ack;
  int   checks = 0;
  int   errors = 0;

  // Model step codes
  localparam int P_DRAIN = 1, P_DFL = 2, P_CFL = 3, P_PAD = 4, P_DONE = 5;
  localparam int O_F = 0, O_FI = 1, O_SV = 2, O_FT = 3;

  fence_sequencer_if if_a ();
  fence_sequencer_if if_b ();

  assign if_a.fence_i = fn;   assign if_b.fence_i = fn;
  assign if_a.fence_i_i = fii; assign if_b.fence_i_i = fii;
  assign if_a.sfence_vma_i = sv; assign if_b.sfence_vma_i = sv;
  assign if_a.fence_t_i = ft;  assign if_b.fence_t_i = ft;
  assign if_a.no_st_pending_i = nsp; assign if_b.no_st_pending_i = nsp;
  assign if_a.dcache_flush_ack_i = ack; assign if_b.dcache_flush_ack_i = ack;

  fence_sequencer #(.DcacheWriteback(1'b1), .FenceTPadCycles(4)) dut_a (
    .clk_i (clk), .rst_ni(rst_n), .bus(if_a));
  fence_sequencer #(.DcacheWriteback(1'b0), .FenceTPadCycles(0)) dut_b (
    .clk_i (clk), .rst_ni(rst_n), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: on acceptance the whole sequence is written out as a list of
  // steps; each cycle the head step is the current activity.
  int plan [2][$];
  int op   [2];

  function automatic bit cfg_wb(input int k);
    return (k == 0);
  endfunction

  function automatic int cfg_pad(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        plan[k].delete();
      end else if (plan[k].size() == 0) begin
        if (ft || fii || fn || sv) begin
          op[k] = ft ? O_FT : fii ? O_FI : fn ? O_F : O_SV;
          plan[k].push_back(P_DRAIN);
          if (op[k] == O_FT || ((op[k] == O_F || op[k] == O_FI) && cfg_wb(k)))
            plan[k].push_back(P_DFL);
          if (op[k] == O_FI || op[k] == O_SV || op[k] == O_FT)
            plan[k].push_back(P_CFL);
          if (op[k] == O_FT)
            for (int n = 0; n < cfg_pad(k); n++) plan[k].push_back(P_PAD);
          plan[k].push_back(P_DONE);
        end
      end else begin
        case (plan[k][0])
          P_DRAIN: if (nsp) void'(plan[k].pop_front());
          P_DFL:   if (ack) void'(plan[k].pop_front());
          default: void'(plan[k].pop_front());
        endcase
      end
    end
  end

  // {busy, dflush, icache, tlb, flush_pipeline, done}
  function automatic logic [5:0] expect_out(input int k);
    int h;
    if (plan[k].size() == 0) return 6'b0;
    h = plan[k][0];
    return {1'b1, h == P_DFL,
            h == P_CFL && (op[k] == O_FI || op[k] == O_FT),
            h == P_CFL && (op[k] == O_SV || op[k] == O_FT),
            h == P_DONE, h == P_DONE};
  endfunction

  function automatic logic [5:0] observe(input int k);
    if (k == 0)
      return {if_a.busy_o, if_a.dcache_flush_o, if_a.icache_flush_o,
              if_a.tlb_flush_o, if_a.flush_pipeline_o, if_a.done_o};
    return {if_b.busy_o, if_b.dcache_flush_o, if_b.icache_flush_o,
            if_b.tlb_flush_o, if_b.flush_pipeline_o, if_b.done_o};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [5:0] o, e;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      o = observe(k);
      e = expect_out(k);
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL outputs_%s t=%0t observed=%b expected=%b", (k == 0) ? "a" : "b", $time, o, e);
      end
    end
  endtask

  // Runs one request until both instances are idle again; the request is
  // dropped on the first done_o, ack follows dcache_flush_o after ack_dly.
  task automatic run_seq(input logic [3:0] req, input int drain_dly, input int ack_dly,
                         input bit stray, output int na, output int nb);
    int cyc, dc;
    bit held, to;
    cyc = 0; dc = 0; na = 0; nb = 0; held = 1'b1; to = 1'b1;
    {ft, fii, fn, sv} = req;
    while (cyc < 300) begin
      nsp = (cyc >= drain_dly);
      ack = 1'b0;
      if (if_a.dcache_flush_o || if_b.dcache_flush_o) begin
        if (dc >= ack_dly) begin ack = 1'b1; dc = 0; end
        else dc++;
      end else begin
        dc = 0;
      end
      if (stray && cyc == 1) begin ack = 1'b1; fn = 1'b1; end
      tick();
      cyc++;
      na += int'(if_a.done_o);
      nb += int'(if_b.done_o);
      if (if_a.done_o || if_b.done_o) begin {ft, fii, fn, sv} = 4'b0; held = 1'b0; end
      if (!held && !if_a.busy_o && !if_b.busy_o) begin to = 1'b0; break; end
    end
    {ft, fii, fn, sv} = 4'b0;
    ack = 1'b0;
    chk("seq_timeout", int'(to), 0);
  endtask

  initial begin
    int na, nb, cnt;
    rst_n = 1'b0; fn = 0; fii = 0; sv = 0; ft = 0; nsp = 0; ack = 0;
    @(negedge clk);
    tick();
    tick();
    chk("reset_busy_a", int'(if_a.busy_o), 0);
    rst_n = 1'b1;
    tick();

    run_seq(4'b0100, 0, 0, 1'b0, na, nb);   // FENCE.I
    chk("fi_done_b", nb, 1);
    run_seq(4'b0010, 5, 3, 1'b0, na, nb);   // FENCE, slow drain, late ack
    chk("f_done_a", na, 1);
    run_seq(4'b1000, 0, 0, 1'b0, na, nb);   // FENCE.T, padded on a
    chk("ft_done_a", na, 1);
    run_seq(4'b1101, 3, 1, 1'b1, na, nb);   // priority, stray ack/request
    chk("prio_done_a", na, 1);
    chk("prio_done_b", nb, 1);

    // Reset while instance a sits in DFLUSH
    fn = 1'b1; nsp = 1'b1;
    tick();
    tick();
    chk("pre_rst_dflush_a", int'(if_a.dcache_flush_o), 1);
    fn = 1'b0; rst_n = 1'b0;
    tick();
    chk("rst_outs_a", int'(observe(0)), 0);
    rst_n = 1'b1;
    run_seq(4'b0001, 0, 0, 1'b0, na, nb);   // SFENCE.VMA after reset
    chk("sv_done_a", na, 1);

    // SFENCE.VMA held for 20 cycles: one done every 4 cycles
    sv = 1'b1; nsp = 1'b1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(if_a.done_o);
    end
    sv = 1'b0;
    chk("sv_held_done_count", cnt, 5);
    repeat (6) tick();
    chk("sv_held_idle_b", int'(if_b.busy_o), 0);

    for (int i = 0; i < 150; i++) begin
      run_seq(4'($urandom_range(1, 15)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), na, nb);
      chk("rand_done_a", na, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
